hash_mem_sequencer: RTL

//  Memory-side initiator for the parallel bitcoin hasher: drives the single-port dpsram

---
 rtl/hash_mem_sequencer_if.sv | 43 ++++
 rtl/hash_mem_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hash_mem_sequencer_if.sv
// Bundle of the sequencer's job, dpsram, header-stream and result-handshake signals.
// master = the sequencer, slave = the memory/core side.
interface hash_mem_sequencer_if #(
  parameter int NUM_NONCES = 16,
  parameter int ADDR_W     = 16
);
  localparam int IW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

  logic              start;
  logic [ADDR_W-1:0] message_addr;
  logic [ADDR_W-1:0] output_addr;
  logic              done;

  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  logic              hdr_valid;
  logic [4:0]        hdr_idx;
  logic [31:0]       hdr_data;
  logic              hdr_done;

  logic              res_valid;
  logic [IW-1:0]     res_idx;
  logic [31:0]       res_data;
  logic              res_ready;

  modport master (
    input  start, message_addr, output_addr, mem_read_data,
           res_valid, res_idx, res_data,
    output done, mem_clk, mem_we, mem_addr, mem_write_data,
           hdr_valid, hdr_idx, hdr_data, hdr_done, res_ready
  );

  modport slave (
    output start, message_addr, output_addr, mem_read_data,
           res_valid, res_idx, res_data,
    input  done, mem_clk, mem_we, mem_addr, mem_write_data,
           hdr_valid, hdr_idx, hdr_data, hdr_done, res_ready
  );
endinterface

// File: rtl/hash_mem_sequencer.sv
// Memory-side initiator for the hasher: streams the header out of the dpsram to the
// cores, then writes each accepted H0 result to output_addr+idx and signals done.
module hash_mem_sequencer #(
  parameter int NUM_NONCES = 16,
  parameter int HDR_WORDS  = 19,
  parameter int ADDR_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  hash_mem_sequencer_if.master bus
);
  localparam int IW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam int CW = $clog2(HDR_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_COLLECT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     rd_cnt_q;
  logic [4:0]        cap_cnt_q;
  logic [IW:0]       res_cnt_q;
  logic [ADDR_W-1:0] msg_base_q;
  logic [ADDR_W-1:0] out_base_q;
  logic              rd_pend_q;

  logic              done_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_write_data_q;
  logic              hdr_valid_q;
  logic [4:0]        hdr_idx_q;
  logic [31:0]       hdr_data_q;
  logic              hdr_done_q;
  logic              res_ready_q;

  logic              res_fire;
  logic              res_in_range;

  assign res_fire     = bus.res_valid && res_ready_q;
  assign res_in_range = {1'b0, bus.res_idx} < (IW+1)'(NUM_NONCES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      rd_cnt_q         <= '0;
      cap_cnt_q        <= '0;
      res_cnt_q        <= '0;
      msg_base_q       <= '0;
      out_base_q       <= '0;
      rd_pend_q        <= 1'b0;
      done_q           <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      hdr_valid_q      <= 1'b0;
      hdr_idx_q        <= '0;
      hdr_data_q       <= '0;
      hdr_done_q       <= 1'b0;
      res_ready_q      <= 1'b0;
    end else begin
      // Read data trails its address by one cycle, so the capture pipeline runs
      // independently of the FSM and drains into COLLECT.
      rd_pend_q   <= (state_q == S_READ) || (state_q == S_CAPTURE);
      hdr_valid_q <= rd_pend_q;
      hdr_done_q  <= rd_pend_q && (cap_cnt_q == 5'(HDR_WORDS - 1));
      if (rd_pend_q) begin
        hdr_idx_q  <= cap_cnt_q;
        hdr_data_q <= bus.mem_read_data;
        cap_cnt_q  <= cap_cnt_q + 5'd1;
      end

      mem_we_q <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q    <= S_READ;
            msg_base_q <= bus.message_addr;
            out_base_q <= bus.output_addr;
            mem_addr_q <= bus.message_addr;
            rd_cnt_q   <= CW'(1);
            cap_cnt_q  <= '0;
            res_cnt_q  <= '0;
            done_q     <= 1'b0;
          end
        end

        S_READ: begin
          mem_addr_q <= msg_base_q + ADDR_W'(rd_cnt_q);
          rd_cnt_q   <= rd_cnt_q + CW'(1);
          if (rd_cnt_q == CW'(HDR_WORDS - 1)) begin
            state_q <= S_CAPTURE;
          end
        end

        // The last header address is on the bus; ready rises so the first result
        // can be accepted while that word is still returning.
        S_CAPTURE: begin
          state_q     <= S_COLLECT;
          res_ready_q <= 1'b1;
        end

        S_COLLECT: begin
          if (res_fire && res_in_range) begin
            mem_we_q         <= 1'b1;
            mem_addr_q       <= out_base_q + ADDR_W'(bus.res_idx);
            mem_write_data_q <= bus.res_data;
            res_cnt_q        <= res_cnt_q + (IW+1)'(1);
            if (res_cnt_q == (IW+1)'(NUM_NONCES - 1)) begin
              state_q     <= S_FLUSH;
              res_ready_q <= 1'b0;
            end
          end
        end

        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end

        default: begin
          state_q     <= S_IDLE;
          res_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_clk        = clk;
  assign bus.done           = done_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.hdr_valid      = hdr_valid_q;
  assign bus.hdr_idx        = hdr_idx_q;
  assign bus.hdr_data       = hdr_data_q;
  assign bus.hdr_done       = hdr_done_q;
  assign bus.res_ready      = res_ready_q;

endmodule
